// File: rtl/div_arbiter_if.sv
// Request/response/divider bundle for div_arbiter.
// Latency: none (wiring only).
// Backpressure: req_ready/rsp_ready valid-ready pairs. The divider side has no backpressure.
// Ports: req_* are per-requester operands packed at [i*W +: W].
//        rsp_* is the shared response channel.
//        div_* is the link to the sequential divider.
interface div_arbiter_if #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int ID_W = 2
);
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_x;
  logic [N*W-1:0]  req_y;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [W-1:0]    rsp_q;
  logic [W-1:0]    rsp_r;
  logic            rsp_error;
  logic            div_reset;
  logic [W-1:0]    div_x;
  logic [W-1:0]    div_y;
  logic [W-1:0]    div_q;
  logic [W-1:0]    div_r;
  logic            div_done;
  logic            div_error;

  // Environment side: the requesters, the response consumer and the divider.
  modport master (
    output req_valid, req_x, req_y, rsp_ready, div_q, div_r, div_done, div_error,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_error, div_reset, div_x, div_y
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_x, req_y, rsp_ready, div_q, div_r, div_done, div_error,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_error, div_reset, div_x, div_y
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one sequential restoring divider among N requesters.
// Latency: accept->rsp_valid is W+2 cycles, or 3 cycles for y==0.
//          With DIV_ZERO_BYPASS_EN defined, y==0 enters RESP on the accept edge.
// Backpressure: a single operation is in flight; req_ready is only raised in IDLE.
//               RESP holds until rsp_ready.
// Ports: clock, reset_n (async active-low) and bus (div_arbiter_if.slave).
// Optional macro: DIV_ZERO_BYPASS_EN (divide-by-zero answered without the divider).
module div_arbiter #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input logic          clock,
  input logic          reset_n,
  div_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            err_q, err_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            div_reset_q, div_reset_d;

  logic [ID_W-1:0] grant_id;
  logic            grant_vld;
  logic [N-1:0]    grant;
  logic [W-1:0]    sel_x;
  logic [W-1:0]    sel_y;

  // Round-robin search starts one past the last accepted port.
  // The last offset (N) wraps back to the pointer itself.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx = ID_W'((int'(ptr_q) + off) % N);
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
    grant = grant_vld ? (N'(1) << grant_id) : '0;
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_x = bus.req_x[i*W +: W];
        sel_y = bus.req_y[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    x_d         = x_q;
    y_d         = y_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    div_reset_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          x_d   = sel_x;
          y_d   = sel_y;
          id_d  = grant_id;
          ptr_d = grant_id;
`ifdef DIV_ZERO_BYPASS_EN
          if (sel_y == '0) begin
            quo_d       = '1;
            rem_d       = sel_x;
            err_d       = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            div_reset_d = 1'b1;
            state_d     = ISSUE;
          end
`else
          div_reset_d = 1'b1;
          state_d     = ISSUE;
`endif
        end
      end
      // The divider is being restarted here.
      // Its done flag still belongs to the previous operation, so it is not looked at.
      ISSUE: state_d = RUN;
      RUN: begin
        if (bus.div_done) begin
          quo_d       = bus.div_q;
          rem_d       = bus.div_r;
          err_d       = bus.div_error;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // div_reset resets high so the divider is held in restart while reset_n is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(N - 1);
      id_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      div_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      x_q         <= x_d;
      y_q         <= y_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      div_reset_q <= div_reset_d;
    end
  end

  // The grant is gated by reset_n so no port appears accepted while reset is asserted.
  assign bus.req_ready = (state_q == IDLE && reset_n) ? grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_q     = quo_q;
  assign bus.rsp_r     = rem_q;
  assign bus.rsp_error = err_q;
  assign bus.div_reset = div_reset_q;
  assign bus.div_x     = x_q;
  assign bus.div_y     = y_q;

endmodule
